// File: rtl/servo_frame_scheduler.sv
// Four-channel servo pulse scheduler sharing one slot counter inside a fixed frame.
// Commands land in shadow registers and are committed to pulse widths only at frame wrap.
module servo_frame_scheduler #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int FRAME_COUNT   = CLK_FREQ / 50,
  parameter int SLOT_COUNT    = 125_000,
  parameter int NEUTRAL_COUNT = 75_000,
  parameter int STEP_SHIFT    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_ch,
  input  logic       cmd_dir,
  input  logic [6:0] cmd_pos,
  output logic [3:0] pwm_out,
  output logic       frame_tick,
  output logic [1:0] active_ch
);

  localparam logic [19:0] FRAME_LAST = 20'(FRAME_COUNT - 1);
  localparam logic [16:0] SLOT_LAST  = 17'(SLOT_COUNT - 1);
  localparam logic [16:0] NEUTRAL_W  = 17'(NEUTRAL_COUNT);

  // Elaboration-time guards: four slots fit a frame, and every width fits its slot.
  if (4 * SLOT_COUNT > FRAME_COUNT) begin : g_chk_frame
    $error("servo_frame_scheduler: four slots do not fit in one frame");
  end
  if (NEUTRAL_COUNT + (127 << STEP_SHIFT) >= SLOT_COUNT) begin : g_chk_slot
    $error("servo_frame_scheduler: maximum pulse width does not fit in a slot");
  end
  if (NEUTRAL_COUNT <= (127 << STEP_SHIFT)) begin : g_chk_neutral
    $error("servo_frame_scheduler: minimum pulse width would underflow");
  end

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ch, ch_nxt;
  logic [16:0] slot_cnt, slot_nxt;
  logic [19:0] frame_cnt;
  logic        wrap;
  logic        accept;

  logic        shadow_dir [4];
  logic [6:0]  shadow_pos [4];
  logic [16:0] width      [4];

  function automatic logic [16:0] calc_width(input logic dir, input logic [6:0] pos);
    logic [16:0] offset;
    offset = 17'(pos) << STEP_SHIFT;
    if (pos == 7'd0)
      return NEUTRAL_W;
    else if (dir)
      return NEUTRAL_W + offset;
    else
      return NEUTRAL_W - offset;
  endfunction

  assign wrap      = (frame_cnt == FRAME_LAST);
  // Blocking the wrap cycle keeps a shadow write from racing the commit.
  assign cmd_ready = !rst && !wrap;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      frame_cnt  <= FRAME_LAST;
      frame_tick <= 1'b0;
    end else begin
      frame_cnt  <= wrap ? 20'd0 : frame_cnt + 20'd1;
      frame_tick <= wrap;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: these small register arrays are reset explicitly so every channel
    // restarts at neutral; a RAM-style array would not be resettable this way.
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        shadow_dir[k] <= 1'b0;
        shadow_pos[k] <= 7'd0;
        width[k]      <= NEUTRAL_W;
      end
    end else begin
      if (accept) begin
        shadow_dir[cmd_ch] <= cmd_dir;
        shadow_pos[cmd_ch] <= cmd_pos;
      end
      if (wrap) begin
        for (int k = 0; k < 4; k++)
          width[k] <= calc_width(shadow_dir[k], shadow_pos[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch       <= 2'd0;
      slot_cnt <= 17'd0;
    end else begin
      state    <= state_nxt;
      ch       <= ch_nxt;
      slot_cnt <= slot_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_nxt = state;
    ch_nxt    = ch;
    slot_nxt  = slot_cnt;
    case (state)
      IDLE: begin
        if (wrap && enable) begin
          state_nxt = PULSE;
          ch_nxt    = 2'd0;
          slot_nxt  = 17'd0;
        end
      end
      PULSE: begin
        slot_nxt = slot_cnt + 17'd1;
        if (slot_cnt == width[ch] - 17'd1)
          state_nxt = GAP;
      end
      GAP: begin
        slot_nxt = slot_cnt + 17'd1;
        if (slot_cnt == SLOT_LAST) begin
          if (ch == 2'd3) begin
            // When four slots exactly fill the frame, the last gap ends on the wrap edge.
            if (wrap && enable) begin
              state_nxt = PULSE;
              ch_nxt    = 2'd0;
              slot_nxt  = 17'd0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            state_nxt = PULSE;
            ch_nxt    = ch + 2'd1;
            slot_nxt  = 17'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pwm_out = 4'b0000;
    if (state == PULSE)
      pwm_out[ch] = 1'b1;
  end

  assign active_ch = (state == IDLE) ? 2'd0 : ch;

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench for servo_frame_scheduler with shrunken frame timing and a pulse scoreboard.
module tb_servo_frame_scheduler;

  localparam int FRAME   = 2000;
  localparam int SLOT    = 400;
  localparam int NEUTRAL = 200;
  localparam int SHIFT   = 0;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_ch;
  logic       cmd_dir;
  logic [6:0] cmd_pos;
  logic [3:0] pwm_out;
  logic       frame_tick;
  logic [1:0] active_ch;

  servo_frame_scheduler #(
    .CLK_FREQ(100_000),
    .FRAME_COUNT(FRAME),
    .SLOT_COUNT(SLOT),
    .NEUTRAL_COUNT(NEUTRAL),
    .STEP_SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch),
    .cmd_dir(cmd_dir),
    .cmd_pos(cmd_pos),
    .pwm_out(pwm_out),
    .frame_tick(frame_tick),
    .active_ch(active_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int off;
    int width;
  } pulse_t;

  pulse_t exp_q[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int rst_events = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_pulse(input int ch, input int off, input int width);
    pulse_t p;
    p.ch = ch;
    p.off = off;
    p.width = width;
    exp_q.push_back(p);
  endtask

  task automatic push_frame(input int w0, input int w1, input int w2, input int w3);
    push_pulse(0, 0, w0);
    push_pulse(1, SLOT, w1);
    push_pulse(2, 2 * SLOT, w2);
    push_pulse(3, 3 * SLOT, w3);
  endtask

  // Reference width from channel command; independent of the RTL arithmetic.
  function automatic int ref_width(input int dir, input int pos);
    if (pos == 0) return NEUTRAL;
    return dir ? NEUTRAL + pos * (1 << SHIFT) : NEUTRAL - pos * (1 << SHIFT);
  endfunction

  // Called just after a falling clock edge; returns one falling edge after acceptance.
  task automatic send_cmd(input int ch, input int dir, input int pos);
    int n;
    cmd_valid = 1'b1;
    cmd_ch    = 2'(ch);
    cmd_dir   = dir[0];
    cmd_pos   = 7'(pos);
    #1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < FRAME + 10);
    check("tick_wait", frame_tick, 1'b1);
  endtask

  always @(posedge clk) cyc++;

  // Pulse monitor: measures offset from frame start and high time, compares with the scoreboard.
  logic [3:0] prev_pwm = 4'b0000;
  int rise_cyc [4];
  int rise_off [4];
  int last_tick = 0;
  int have_tick = 0;
  int tick_rst_events = 0;

  always @(negedge clk) begin
    pulse_t p;
    if (frame_tick === 1'b1) begin
      if (have_tick != 0 && tick_rst_events == rst_events)
        check("tick_period", cyc - last_tick, FRAME);
      have_tick = 1;
      last_tick = cyc;
      tick_rst_events = rst_events;
    end
    for (int k = 0; k < 4; k++) begin
      if (pwm_out[k] === 1'b1 && prev_pwm[k] === 1'b0) begin
        rise_cyc[k] = cyc;
        rise_off[k] = cyc - last_tick;
        check("pwm_onehot", $countones(pwm_out), 1);
      end
      if (pwm_out[k] === 1'b0 && prev_pwm[k] === 1'b1) begin
        check("pulse_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          check("pulse_ch", k, p.ch);
          check("pulse_offset", rise_off[k], p.off);
          check("pulse_width", cyc - rise_cyc[k], p.width);
        end
      end
    end
    prev_pwm = pwm_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    enable    = 1'b1;
    cmd_valid = 1'b0;
    cmd_ch    = 2'd0;
    cmd_dir   = 1'b0;
    cmd_pos   = 7'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 4'b0000);
    check("rst_tick", frame_tick, 1'b0);
    check("rst_active_ch", active_ch, 2'd0);
    check("rst_cmd_ready", cmd_ready, 1'b0);

    // Frame 1: neutral on all channels; first wrap on the first edge with rst low.
    push_frame(NEUTRAL, NEUTRAL, NEUTRAL, NEUTRAL);
    rst = 1'b0;
    #1;
    check("ready_first_wrap", cmd_ready, 1'b0);
    @(negedge clk);
    check("first_tick", frame_tick, 1'b1);
    check("first_pwm", pwm_out, 4'b0001);
    check("first_active_ch", active_ch, 2'd0);
    check("first_ready", cmd_ready, 1'b1);

    repeat (100) @(negedge clk);
    send_cmd(2, 1, 10);
    push_frame(NEUTRAL, NEUTRAL, ref_width(1, 10), NEUTRAL);

    // Frame 2: last write to ch1 wins.
    wait_tick();
    send_cmd(1, 0, 127);
    send_cmd(1, 1, 0);
    push_frame(NEUTRAL, NEUTRAL, ref_width(1, 10), NEUTRAL);

    // Frame 3: minimum width on ch1.
    wait_tick();
    send_cmd(1, 0, 127);
    push_frame(NEUTRAL, ref_width(0, 127), ref_width(1, 10), NEUTRAL);

    // Frame 4: hold a command across the wrap.
    wait_tick();
    push_frame(NEUTRAL, ref_width(0, 127), ref_width(1, 10), NEUTRAL);
    repeat (FRAME - 2) @(negedge clk);
    check("ready_before_wrap", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_ch    = 2'd0;
    cmd_dir   = 1'b1;
    cmd_pos   = 7'd5;
    #1;
    check("ready_at_wrap", cmd_ready, 1'b0);
    @(negedge clk);
    check("wrap_tick", frame_tick, 1'b1);
    check("ready_after_wrap", cmd_ready, 1'b1);
    @(negedge clk);
    cmd_valid = 1'b0;
    push_frame(ref_width(1, 5), ref_width(0, 127), ref_width(1, 10), NEUTRAL);

    // Frame 6: drop enable in ch1's slot; this frame still completes.
    wait_tick();
    repeat (SLOT + 50) @(negedge clk);
    check("slot1_active_ch", active_ch, 2'd1);
    check("slot1_pwm", pwm_out, 4'b0010);
    enable = 1'b0;
    send_cmd(0, 1, 127);

    // Frame 7: no pulses while ticks continue.
    wait_tick();
    check("idle_pwm", pwm_out, 4'b0000);
    check("idle_active_ch", active_ch, 2'd0);
    repeat (SLOT) @(negedge clk);
    check("idle_pwm_mid", pwm_out, 4'b0000);
    enable = 1'b1;
    push_frame(ref_width(1, 127), ref_width(0, 127), ref_width(1, 10), NEUTRAL);

    // Frame 8: reset during ch0's maximum-width pulse truncates it to 50 cycles.
    wait_tick();
    check("frame8_pwm", pwm_out, 4'b0001);
    send_cmd(3, 1, 50);
    repeat (48) @(negedge clk);
    exp_q.pop_back();
    exp_q.pop_back();
    exp_q.pop_back();
    exp_q.pop_back();
    push_pulse(0, 0, 50);
    rst = 1'b1;
    rst_events++;
    @(negedge clk);
    check("midrst_pwm", pwm_out, 4'b0000);
    check("midrst_active_ch", active_ch, 2'd0);
    check("midrst_ready", cmd_ready, 1'b0);
    check("midrst_tick", frame_tick, 1'b0);
    push_frame(NEUTRAL, NEUTRAL, NEUTRAL, NEUTRAL);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_tick", frame_tick, 1'b1);
    check("postrst_pwm", pwm_out, 4'b0001);
    enable = 1'b0;

    wait_tick();
    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/servo_frame_scheduler.md
# servo_frame_scheduler

Time-multiplexed servo pulse scheduler that shares a single pulse-width counter among four servo channels inside one 20 ms frame. Each channel gets a fixed 2.5 ms slot. Commands (channel, direction, position) arrive over a valid/ready port into shadow registers. Shadow values are committed to the active pulse widths only at frame boundaries, so no pulse is ever truncated or stretched mid-output.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- FRAME_COUNT, CLK_FREQ/50 (1_000_000), clocks per 20 ms frame
- SLOT_COUNT, 125_000, clocks per channel slot (2.5 ms)
- NEUTRAL_COUNT, 75_000, neutral pulse width in clocks (1.5 ms)
- STEP_SHIFT, 8, position-to-clocks scale; offset = pos << STEP_SHIFT
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- enable  in  1  pulse generation enable, sampled only at frame start
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_ch  in  2  target channel 0..3
- cmd_dir  in  1  0 = left (subtract), 1 = right (add)
- cmd_pos  in  7  position magnitude; 0 = neutral
- pwm_out  out  4  one pulse line per channel
- frame_tick  out  1  one-cycle strobe at each frame start
- active_ch  out  2  channel currently in its slot (0 when IDLE)

## Operation
- Frame counter: 20 bits, counts 0..FRAME_COUNT-1 then wraps to 0. Reset value is FRAME_COUNT-1, so the first wrap occurs on the first clock edge with rst low.
- Shadow registers: per channel {dir, pos}. An accepted command overwrites the addressed channel. Multiple writes to one channel within a frame: last write wins.
- cmd_ready: 1 except in the wrap cycle (frame counter == FRAME_COUNT-1) and while rst is high. Writes therefore never collide with commit.
- Commit: on the wrap edge, width[k] is computed from shadow[k] for all k:
  - pos == 0: NEUTRAL_COUNT.
  - dir == 1: NEUTRAL_COUNT + (pos << STEP_SHIFT).
  - dir == 0: NEUTRAL_COUNT - (pos << STEP_SHIFT).
  - Widths are 17-bit unsigned. With default parameters, range is 42_488..107_512.
- FSM states IDLE, PULSE, GAP, with slot counter slot_cnt (17 bits) and channel index ch (2 bits):
  - IDLE -> PULSE on the wrap edge if enable = 1; ch <= 0, slot_cnt <= 0. Otherwise remain in IDLE.
  - PULSE: slot_cnt increments each cycle. When slot_cnt == width[ch]-1, go to GAP.
  - GAP: slot_cnt increments. When slot_cnt == SLOT_COUNT-1: if ch == 3 go to IDLE, else ch <= ch+1, slot_cnt <= 0, go to PULSE.
- pwm_out[k] = (state == PULSE) && (ch == k), decoded from registered state. Exactly one channel can be high at any time.
- enable deasserted mid-frame: the current frame completes normally. The next frame is not started.
- Parameter constraints, checked by elaboration assertion:
  - 4*SLOT_COUNT <= FRAME_COUNT.
  - NEUTRAL_COUNT + (127 << STEP_SHIFT) < SLOT_COUNT.
  - NEUTRAL_COUNT > (127 << STEP_SHIFT).

## Timing
- Reset values:
  - pwm_out = 0, frame_tick = 0, active_ch = 0, cmd_ready = 0.
  - State IDLE.
  - All shadows and widths at neutral (pos 0, width NEUTRAL_COUNT).
- frame_tick is registered and high for exactly one cycle, the cycle after the wrap edge. Its period is FRAME_COUNT clocks.
- Channel k pulse: rising edge at wrap edge + k*SLOT_COUNT cycles; high for exactly width[k] cycles.
- Command latency: a command accepted in frame N takes effect in frame N+1. A command accepted in the last cycle before the wrap is impossible because cmd_ready = 0 in that cycle.
- rst asserted mid-pulse: pwm_out goes to 0 on the next edge, and shadow and width values return to neutral. After rst is released, the first frame starts on the next edge.

## Test plan
- Release reset with enable = 1 and no commands -> each channel pulses 75_000 cycles high, starting at offsets 0, 125_000, 250_000, 375_000 from frame start. frame_tick fires every 1_000_000 cycles.
- Accept cmd ch=2, dir=1, pos=10 mid-frame -> no change in the current frame. Next frame: ch2 width 77_560, other channels unchanged.
- Accept cmd ch=1, dir=0, pos=127, then ch=1, dir=1, pos=0 in the same frame -> next frame ch1 width 75_000 (last write wins). Repeat with only pos=127, dir=0 -> width 42_488.
- Hold cmd_valid high across a wrap -> cmd_ready = 0 exactly in the cycle with frame counter == 999_999. The command is accepted the following cycle and applied one frame later.
- Drop enable during ch1's slot -> ch1..ch3 still complete their pulses. The next frame has no pulses while frame_tick continues. Raising enable again restarts pulses at the following frame.
- Assert rst for 1 cycle during ch0's pulse with ch0 width 107_512 -> pwm_out = 0 next cycle. The new frame starts the cycle after rst falls, with all widths at 75_000.
